// File: rtl/uart_tx_sched.sv
// Round-robin transmit scheduler sharing one UART line among NREQ requesters.
// Optional even-parity bit between data and stop: define UART_SCHED_PARITY_EN.
module uart_tx_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned OWN_W = 2
) (
  input  logic               clkin,
  input  logic               reset,
  input  logic [15:0]        divisor,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*8-1:0]  data,
  output logic [NREQ-1:0]    grant,
  output logic [OWN_W-1:0]   owner,
  output logic               busy,
  output logic               dout,
  output logic               clkout,
  output logic               intr
);

  localparam int unsigned DIV_W  = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 3;

`ifdef UART_SCHED_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t             state;
  logic [DIV_W-1:0]   cnt;
  logic [DIV_W-1:0]   dreg;
  logic [BYTE_W-1:0]  byte_q;
  logic [IDX_W-1:0]   idx;
  logic [OWN_W-1:0]   ptr;

  logic [OWN_W-1:0]   win;
  logic [OWN_W-1:0]   cand;
  logic               found;
  logic [BYTE_W-1:0]  sel_byte;
  logic               tick;

  assign tick = (state != IDLE) && (cnt == dreg - DIV_W'(1));

  // Round-robin search starting one past the last winner, with wrap.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = OWN_W'((32'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    sel_byte = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win == OWN_W'(i)) sel_byte = data[BYTE_W*i +: BYTE_W];
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      dreg   <= DIV_W'(1);
      byte_q <= '0;
      idx    <= '0;
      ptr    <= OWN_W'(NREQ - 1);
      grant  <= '0;
      owner  <= '0;
      busy   <= 1'b0;
      dout   <= 1'b1;
      clkout <= 1'b0;
      intr   <= 1'b0;
    end else begin
      grant  <= '0;
      intr   <= 1'b0;
      clkout <= tick;
      if (state == IDLE) cnt <= '0;
      else               cnt <= tick ? '0 : cnt + DIV_W'(1);

      case (state)
        IDLE: begin
          dout <= 1'b1;
          busy <= 1'b0;
          if (found) begin
            state  <= START;
            byte_q <= sel_byte;
            dreg   <= (divisor == '0) ? DIV_W'(1) : divisor;
            owner  <= win;
            ptr    <= win;
            grant  <= NREQ'(1) << win;
            busy   <= 1'b1;
            dout   <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            idx   <= '0;
            dout  <= byte_q[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (idx == IDX_W'(BYTE_W - 1)) begin
`ifdef UART_SCHED_PARITY_EN
              state <= PARITY;
              dout  <= ^byte_q;
`else
              state <= STOP;
              dout  <= 1'b1;
`endif
            end else begin
              idx  <= idx + IDX_W'(1);
              dout <= byte_q[idx + IDX_W'(1)];
            end
          end
        end
`ifdef UART_SCHED_PARITY_EN
        PARITY: begin
          if (tick) begin
            state <= STOP;
            dout  <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            state <= IDLE;
            intr  <= 1'b1;
            busy  <= 1'b0;
            dout  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed and random frames checked against a frame-level model.
module tb_uart_tx_sched;

  localparam int NREQ  = 4;
  localparam int OWN_W = 2;
`ifdef UART_SCHED_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [15:0]       divisor;
  logic [NREQ-1:0]   req;
  logic [NREQ*8-1:0] data;
  logic [NREQ-1:0]   grant;
  logic [OWN_W-1:0]  owner;
  logic              busy, dout, clkout, intr;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last;
  int last_gcyc = 0;
  logic [7:0] bytes [NREQ];

  uart_tx_sched #(.NREQ(NREQ), .OWN_W(OWN_W)) dut (
    .clkin(clk), .reset(reset), .divisor(divisor), .req(req), .data(data),
    .grant(grant), .owner(owner), .busy(busy), .dout(dout),
    .clkout(clkout), .intr(intr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pack_data();
    logic [NREQ*8-1:0] d;
    d = '0;
    for (int i = NREQ - 1; i >= 0; i--) d = (d << 8) | (NREQ*8)'(bytes[i]);
    data = d;
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int from);
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (from + k) % NREQ;
      if (r[c[OWN_W-1:0]]) return c;
    end
    return -1;
  endfunction

  task automatic wait_grant(output bit ok);
    int n;
    n = 0;
    while (grant === '0 && n < 200) begin
      step();
      n++;
    end
    ok = (grant !== '0);
    if (!ok) chk("grant_timeout", 32'(0), 32'(1));
  endtask

  // Waits for the next grant and checks the whole frame cycle by cycle.
  task automatic frame_check(input bit drop, input int exp_gap, input int mid_c,
                             input logic [15:0] mid_div, input logic [NREQ-1:0] mid_req);
    bit ok;
    int w, dr, bi, k;
    logic [7:0] b;
    logic [FB-1:0] bits;
    logic [NREQ-1:0] oh;
    wait_grant(ok);
    if (!ok) return;
    w = rr_pick(req, last);
    if (w < 0) begin
      chk("spurious_grant", 32'(grant), 32'(0));
      return;
    end
    dr = (divisor == 16'd0) ? 1 : int'(divisor);
    b  = bytes[w];
    oh = '0;
    oh[w[OWN_W-1:0]] = 1'b1;
    if (exp_gap > 0) chk("grant_gap", 32'(cyc - last_gcyc), 32'(exp_gap));
    last_gcyc = cyc;
    bits = '0;
    for (int i = 0; i < 8; i++) begin
      k = i + 1;
      bits[k[3:0]] = b[i[2:0]];
    end
`ifdef UART_SCHED_PARITY_EN
    bits[9] = ^b;
`endif
    bits[FB-1] = 1'b1;
    for (int c = 0; c < FB * dr; c++) begin
      bi = c / dr;
      chk("dout", 32'(dout), 32'(bits[bi[3:0]]));
      chk("busy", 32'(busy), 32'(1));
      chk("owner", 32'(owner), 32'(w));
      chk("grant", 32'(grant), (c == 0) ? 32'(oh) : 32'(0));
      chk("clkout", 32'(clkout), 32'((c > 0) && (c % dr == 0)));
      chk("intr_early", 32'(intr), 32'(0));
      if (c == 0 && drop) req[w[OWN_W-1:0]] = 1'b0;
      if (c == mid_c) begin
        divisor = mid_div;
        req = req | mid_req;
      end
      step();
    end
    chk("intr_end", 32'(intr), 32'(1));
    chk("busy_end", 32'(busy), 32'(0));
    chk("dout_end", 32'(dout), 32'(1));
    chk("clkout_end", 32'(clkout), 32'(1));
    chk("grant_end", 32'(grant), 32'(0));
    last = w;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    last = NREQ - 1;
  endtask

  initial begin
    reset = 1'b1; req = '0; divisor = 16'd4;
    for (int i = 0; i < NREQ; i++) bytes[i] = 8'h00;
    pack_data();
    last = NREQ - 1;
    step(); step();
    chk("rst_dout", 32'(dout), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_grant", 32'(grant), 32'(0));
    chk("rst_owner", 32'(owner), 32'(0));
    chk("rst_clkout", 32'(clkout), 32'(0));
    chk("rst_intr", 32'(intr), 32'(0));
    reset = 1'b0;
    step();

    // Single frame, 0xA5 at 4 cycles per bit
    bytes[0] = 8'hA5; pack_data();
    req = 4'b0001;
    frame_check(1'b1, 0, -1, 16'd0, '0);

    // Round-robin with all requesters held
    do_reset();
    divisor = 16'd1;
    for (int i = 0; i < NREQ; i++) bytes[i] = 8'($urandom);
    pack_data();
    req = 4'b1111;
    for (int f = 0; f < 5; f++) frame_check(1'b0, (f == 0) ? 0 : 11, -1, 16'd0, '0);
    req = '0;
    step(); step();

    // Divisor 0 behaves as 1
    divisor = 16'd0; bytes[2] = 8'h00; pack_data();
    req = 4'b0100;
    frame_check(1'b1, 0, -1, 16'd0, '0);
    step();

    // Divisor change and late request mid-frame
    divisor = 16'd8; bytes[0] = 8'($urandom); bytes[1] = 8'($urandom); pack_data();
    req = 4'b0001;
    frame_check(1'b1, 0, 20, 16'd2, 4'b0010);
    frame_check(1'b1, 81, -1, 16'd0, '0);
    step();

    // Reset mid-frame during data bit 3
    begin
      bit ok;
      divisor = 16'd4; bytes[2] = 8'h3C; pack_data();
      req = 4'b0100;
      wait_grant(ok);
      req = '0;
      repeat (17) step();
      reset = 1'b1;
      #1;
      chk("abort_dout", 32'(dout), 32'(1));
      chk("abort_busy", 32'(busy), 32'(0));
      chk("abort_owner", 32'(owner), 32'(0));
      chk("abort_grant", 32'(grant), 32'(0));
      for (int i = 0; i < 3; i++) begin
        step();
        chk("abort_intr", 32'(intr), 32'(0));
      end
      reset = 1'b0;
      last = NREQ - 1;
      step();
      for (int i = 0; i < 50; i++) begin
        chk("post_abort_intr", 32'(intr), 32'(0));
        step();
      end
    end

    // Pointer restarts at NREQ-1: requester 0 beats requester 3
    divisor = 16'd3; bytes[0] = 8'h5A; bytes[3] = 8'hC3; pack_data();
    req = 4'b1001;
    frame_check(1'b1, 0, -1, 16'd0, '0);
    frame_check(1'b1, 31, -1, 16'd0, '0);

`ifdef UART_SCHED_PARITY_EN
    step();
    divisor = 16'd2; bytes[1] = 8'h07; pack_data();
    req = 4'b0010;
    frame_check(1'b1, 0, -1, 16'd0, '0);
`endif

    // Random frames with reqs held until their grant
    for (int f = 0; f < 8; f++) begin
      if (req == '0) req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) bytes[i] = 8'($urandom);
      pack_data();
      divisor = 16'($urandom_range(0, 5));
      frame_check(1'b1, 0, -1, 16'd0, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
